fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

- Pointer/flag controller that drives the dual-port RAM memory of the main FIFO.
- Accepts push/pop requests from producer and consumer, and generates the RAM write/read enables and write/read pointers.
- Tracks occupancy and reports full/empty, almost-full/almost-empty and sticky overflow/underflow errors.
- Sits between the FIFO's external handshake and its storage array; it never touches data.

## Interface
- ADDR_SIZE, 3: pointer width; FIFO depth = 2**ADDR_SIZE.
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  producer write request.
- pop  input  1  consumer read request.
- af_thresh  input  ADDR_SIZE+1  almost-full threshold, sampled every cycle.
- ae_thresh  input  ADDR_SIZE+1  almost-empty threshold, sampled every cycle.
- ram_write  output  1  RAM write enable, combinational.
- ram_read  output  1  RAM read enable, combinational.
- wr_ptr  output  ADDR_SIZE  RAM write address, registered.
- rd_ptr  output  ADDR_SIZE  RAM read address, registered.
- rd_valid  output  1  RAM data_out valid; registered, one cycle after accepted pop.
- count  output  ADDR_SIZE+1  occupancy, registered.
- full, empty, almost_full, almost_empty  output  1 each  status flags, registered.
- overflow, underflow  output  1 each  sticky error flags, cleared only by reset.

## Operation
- State machine, 3 states:
  - EMPTY: count = 0.
  - ACTIVE: 0 < count < depth.
  - FULL: count = depth.
  - Next state is derived from the next count; flags are decoded from the registered state.
- Push accept (push_ok):
  - In EMPTY or ACTIVE: push_ok = push.
  - In FULL: push_ok = push & pop.
- Pop accept (pop_ok):
  - In ACTIVE or FULL: pop_ok = pop.
  - In EMPTY: never accepted, even with a simultaneous push.
- RAM strobes: ram_write = push_ok & ~reset; ram_read = pop_ok & ~reset.
- Pointers: wr_ptr increments on push_ok and rd_ptr increments on pop_ok, modulo 2**ADDR_SIZE (natural wrap 7 -> 0).
- Count update: +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither.
- Error flags:
  - overflow sets when push is asserted in FULL without pop.
  - underflow sets when pop is asserted in EMPTY.
  - Rejected requests never move pointers or count.
- Threshold flags:
  - almost_full = (count >= af_thresh).
  - almost_empty = (count <= ae_thresh).
  - Both use unsigned compare on ADDR_SIZE+1 bits.
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0, state EMPTY, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0, rd_valid = 0.
- Reset mid-operation:
  - push/pop in the reset cycle are ignored.
  - RAM strobes are forced to 0.
  - Previously stored data is abandoned.

## Timing
- push_ok in cycle N: RAM writes at edge N; count, flags and wr_ptr update at edge N.
- pop_ok in cycle N: RAM captures data_out at edge N; rd_valid = 1 throughout cycle N+1.
- Back-to-back pops give continuous rd_valid.
- Push into EMPTY at cycle N: earliest accepted pop is cycle N+1; data valid in N+2.
- Simultaneous push+pop in FULL reads the old entry before it is overwritten, because the RAM read/write ordering is registered.

## Structure
- Shared package fifo_pkg holds:
  - state encoding typedef (EMPTY, ACTIVE, FULL);
  - default ADDR_SIZE constant;
  - depth localparam function.
- Sub-module fifo_ptr: wrap-around ADDR_SIZE-bit pointer with increment enable and synchronous reset.
  - Instantiated twice, once for wr_ptr and once for rd_ptr.

## Test plan
All scenarios use ADDR_SIZE = 3 (depth 8).
- Reset check: hold reset 2 cycles with push = 1 and pop = 1 -> all outputs at reset values, ram_write = 0, ram_read = 0, count = 0.
- Fill/drain:
  - 8 pushes -> count = 8, full = 1, wr_ptr wrapped to 0.
  - Then 8 pops -> rd_valid high for 8 consecutive cycles, empty = 1, rd_ptr = 0.
- Overflow: at full, push without pop -> ram_write = 0, count stays 8, overflow = 1 and stays 1 after subsequent pops.
- Underflow: pop when empty, with and without a simultaneous push -> ram_read = 0, underflow = 1; with push, count = 1.
- Full push+pop: at count 8, push = pop = 1 -> both strobes 1, count stays 8, both pointers advance by 1, no overflow.
- Thresholds: af_thresh = 6, ae_thresh = 2.
  - 6 pushes -> almost_full = 1 on the edge count reaches 6.
  - Then pops -> almost_empty = 1 on the edge count reaches 2.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the FIFO pointer/flag controller.
package fifo_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StActive,
    StFull
  } fifo_state_e;

  parameter int unsigned AddrSizeDefault = 3;

  function automatic int unsigned fifo_depth(int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around RAM address pointer with increment enable and synchronous reset.
module fifo_ptr #(
  parameter int unsigned ADDR_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [ADDR_SIZE-1:0] ptr
);

  logic [ADDR_SIZE-1:0] ptr_q;

  // Natural binary overflow provides the modulo-depth wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (inc) begin
      ptr_q <= ptr_q + ADDR_SIZE'(1);
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller: accepts push/pop, drives RAM strobes and
// pointers, tracks occupancy and reports status and sticky error flags.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = AddrSizeDefault
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [ADDR_SIZE:0]   af_thresh,
  input  logic [ADDR_SIZE:0]   ae_thresh,
  output logic                 ram_write,
  output logic                 ram_read,
  output logic [ADDR_SIZE-1:0] wr_ptr,
  output logic [ADDR_SIZE-1:0] rd_ptr,
  output logic                 rd_valid,
  output logic [ADDR_SIZE:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [ADDR_SIZE:0] DepthCnt = (ADDR_SIZE + 1)'(fifo_depth(ADDR_SIZE));

  fifo_state_e          state_q, state_d;
  logic [ADDR_SIZE:0]   count_q, count_d;
  logic                 push_ok, pop_ok;
  logic                 rd_valid_q;
  logic                 almost_full_q, almost_empty_q;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  always_comb begin
    push_ok     = 1'b0;
    pop_ok      = 1'b0;
    count_d     = count_q;
    state_d     = state_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    unique case (state_q)
      StEmpty: begin
        push_ok     = push;
        underflow_d = underflow_q | pop;
      end
      StActive: begin
        push_ok = push;
        pop_ok  = pop;
      end
      StFull: begin
        // A full FIFO only takes a write when a read frees the slot that cycle.
        push_ok    = push & pop;
        pop_ok     = pop;
        overflow_d = overflow_q | (push & ~pop);
      end
      default: ;
    endcase

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (ADDR_SIZE + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_SIZE + 1)'(1);
      default: count_d = count_q;
    endcase

    if (count_d == '0) begin
      state_d = StEmpty;
    end else if (count_d == DepthCnt) begin
      state_d = StFull;
    end else begin
      state_d = StActive;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StEmpty;
      count_q        <= '0;
      rd_valid_q     <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      rd_valid_q     <= pop_ok;
      almost_full_q  <= (count_d >= af_thresh);
      almost_empty_q <= (count_d <= ae_thresh);
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  fifo_ptr #(
    .ADDR_SIZE(ADDR_SIZE)
  ) u_wr_ptr (
    .clk  (clk),
    .reset(reset),
    .inc  (push_ok),
    .ptr  (wr_ptr)
  );

  fifo_ptr #(
    .ADDR_SIZE(ADDR_SIZE)
  ) u_rd_ptr (
    .clk  (clk),
    .reset(reset),
    .inc  (pop_ok),
    .ptr  (rd_ptr)
  );

  assign ram_write    = push_ok & ~reset;
  assign ram_read     = pop_ok & ~reset;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign empty        = (state_q == StEmpty);
  assign full         = (state_q == StFull);
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed and randomized checks of fifo_ctrl against an occupancy-level model.
module tb_fifo_ctrl;

  localparam int Depth = 8;

  logic       clk;
  logic       reset;
  logic       push;
  logic       pop;
  logic [3:0] af_thresh;
  logic [3:0] ae_thresh;
  logic       ram_write;
  logic       ram_read;
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic       rd_valid;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  fifo_ctrl #(
    .ADDR_SIZE(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .af_thresh   (af_thresh),
    .ae_thresh   (ae_thresh),
    .ram_write   (ram_write),
    .ram_read    (ram_read),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .rd_valid    (rd_valid),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model: occupancy and addresses as plain integers.
  int m_cnt = 0;
  int m_wr  = 0;
  int m_rd  = 0;
  bit m_ovf = 0;
  bit m_unf = 0;
  bit m_rv  = 0;
  bit m_af  = 0;
  bit m_ae  = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    check("count", 32'(count), 32'(m_cnt));
    check("wr_ptr", 32'(wr_ptr), 32'(m_wr));
    check("rd_ptr", 32'(rd_ptr), 32'(m_rd));
    check("full", 32'(full), 32'(m_cnt == Depth));
    check("empty", 32'(empty), 32'(m_cnt == 0));
    check("almost_full", 32'(almost_full), 32'(m_af));
    check("almost_empty", 32'(almost_empty), 32'(m_ae));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
    check("rd_valid", 32'(rd_valid), 32'(m_rv));
  endtask

  // Called at posedge+1: drive, check strobes, clock, update model, check state.
  task automatic step(input bit p, input bit q);
    bit p_ok;
    bit q_ok;
    push = p;
    pop  = q;
    p_ok = p && (m_cnt < Depth || q);
    q_ok = q && (m_cnt > 0);
    #2;
    check("ram_write", 32'(ram_write), 32'(p_ok && !reset));
    check("ram_read", 32'(ram_read), 32'(q_ok && !reset));
    @(posedge clk);
    if (reset) begin
      m_cnt = 0; m_wr = 0; m_rd = 0;
      m_ovf = 0; m_unf = 0; m_rv = 0; m_af = 0; m_ae = 1;
    end else begin
      if (m_cnt == Depth && p && !q) m_ovf = 1;
      if (m_cnt == 0 && q) m_unf = 1;
      m_cnt = m_cnt + int'(p_ok) - int'(q_ok);
      m_wr  = (m_wr + int'(p_ok)) % Depth;
      m_rd  = (m_rd + int'(q_ok)) % Depth;
      m_rv  = q_ok;
      m_af  = (m_cnt >= int'(af_thresh));
      m_ae  = (m_cnt <= int'(ae_thresh));
    end
    #1;
    check_regs();
  endtask

  initial begin
    reset     = 1'b1;
    push      = 1'b0;
    pop       = 1'b0;
    af_thresh = 4'd6;
    ae_thresh = 4'd2;
    #6;

    // Reset held two cycles with both requests asserted.
    step(1, 1);
    step(1, 1);
    reset = 1'b0;

    // Fill and drain.
    repeat (8) step(1, 0);
    check("fill_count", 32'(count), 32'd8);
    check("fill_wrap", 32'(wr_ptr), 32'd0);
    check("fill_full", 32'(full), 32'd1);
    repeat (8) step(0, 1);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_rdptr", 32'(rd_ptr), 32'd0);

    // Underflow, alone and with a simultaneous push.
    step(0, 1);
    check("unf_set", 32'(underflow), 32'd1);
    step(1, 1);
    check("unf_push_count", 32'(count), 32'd1);

    // Refill, then push+pop at full.
    repeat (7) step(1, 0);
    step(1, 1);
    check("fullpp_count", 32'(count), 32'd8);
    check("fullpp_noovf", 32'(overflow), 32'd0);

    // Overflow is sticky across pops.
    step(1, 0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    step(0, 1);
    step(0, 1);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Threshold flags from a clean reset.
    reset = 1'b1;
    step(0, 0);
    reset = 1'b0;
    repeat (6) step(1, 0);
    check("af_at6", 32'(almost_full), 32'd1);
    repeat (4) step(0, 1);
    check("ae_at2", 32'(almost_empty), 32'd1);

    // Randomized traffic with occasional threshold changes and resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        af_thresh = 4'($urandom_range(0, 9));
        ae_thresh = 4'($urandom_range(0, 9));
      end
      reset = ($urandom_range(0, 99) == 0);
      if (i < 250) step(($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 40));
      else         step(($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 65));
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
